// File: rtl/stopwatch_lap_ctrl_if.sv
// Lap readout channel between the stopwatch control block (master) and the
// display/readout consumer (slave): valid/ready head-of-FIFO plus status.
interface stopwatch_lap_ctrl_if #(
   parameter int LAP_DEPTH = 4
);
   localparam int CW = $clog2(LAP_DEPTH) + 1;

   logic          lap_valid;
   logic          lap_ready;
   logic [11:0]   lap_data;
   logic [CW-1:0] lap_count;
   logic          lap_overflow;

   modport master (
      output lap_valid,
      output lap_data,
      output lap_count,
      output lap_overflow,
      input  lap_ready
   );

   modport slave (
      input  lap_valid,
      input  lap_data,
      input  lap_count,
      input  lap_overflow,
      output lap_ready
   );
endinterface

// File: rtl/stopwatch_lap_ctrl.sv
// Run/pause/clear sequencer with count-enable prescaler and a lap FIFO that
// snapshots {minutes, seconds} for a valid/ready readout consumer.
module stopwatch_lap_ctrl #(
   parameter int TICK_DIV  = 100,
   parameter int LAP_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  reset,
   input  logic                  lap,
   input  logic [5:0]            cur_min,
   input  logic [5:0]            cur_sec,
   output logic                  count_en,
   output logic                  cnt_clr,
   output logic [1:0]            status,
   stopwatch_lap_ctrl_if.master  lap_if
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int AW = $clog2(LAP_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(LAP_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUNNING = 2'b01,
      ST_PAUSED  = 2'b10
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          count_en_q, count_en_d;
   logic          cnt_clr_q, cnt_clr_d;

   logic [11:0]   mem_q [LAP_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          valid_q, valid_d;
   logic [11:0]   head_q, head_d;
   logic          ovf_q, ovf_d;

   logic          running_s;
   logic          wrap_s;
   logic          pop_s;
   logic          full_s;
   logic          lap_act_s;
   logic          push_s;
   logic [11:0]   lap_word_s;
   logic [AW-1:0] rd_next_s;

   // Next-state logic: reset dominates, stop dominates start.
   always_comb begin
      state_d = state_q;
      if (reset) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !stop) state_d = ST_RUNNING;
               else                state_d = ST_IDLE;
            end
            ST_RUNNING: begin
               if (stop) state_d = ST_PAUSED;
               else      state_d = ST_RUNNING;
            end
            ST_PAUSED: begin
               if (stop)       state_d = ST_PAUSED;
               else if (start) state_d = ST_RUNNING;
               else            state_d = ST_PAUSED;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Prescaler advances only while running; the tick is cancelled by a clear.
   always_comb begin
      running_s  = (state_q == ST_RUNNING);
      wrap_s     = running_s && (presc_q == PRE_MAX);
      presc_d    = presc_q;
      if (reset) begin
         presc_d = '0;
      end else if (running_s) begin
         if (wrap_s) presc_d = '0;
         else        presc_d = presc_q + PW'(1);
      end else begin
         presc_d = presc_q;
      end
      count_en_d = wrap_s && !reset;
      cnt_clr_d  = reset;
   end

   // FIFO control: push, pop, occupancy, sticky overflow and registered head.
   always_comb begin
      lap_word_s = {cur_min, cur_sec};
      pop_s      = valid_q && lap_if.lap_ready && !reset;
      full_s     = (count_q == DEPTH_C);
      lap_act_s  = lap && !reset && (state_q != ST_IDLE);
      push_s     = lap_act_s && (!full_s || pop_s);
      rd_next_s  = rd_ptr_q + AW'(1);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      head_d   = head_q;

      if (reset) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         head_d   = 12'h000;
      end else begin
         if (push_s) wr_ptr_d = wr_ptr_q + AW'(1);
         else        wr_ptr_d = wr_ptr_q;
         if (pop_s)  rd_ptr_d = rd_next_s;
         else        rd_ptr_d = rd_ptr_q;

         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase

         if (lap_act_s && full_s && !pop_s) ovf_d = 1'b1;
         else                               ovf_d = ovf_q;

         // Head tracks what rd_ptr will point at after this edge.
         if (pop_s) begin
            if (count_q > CW'(1)) head_d = mem_q[rd_next_s];
            else if (push_s)      head_d = lap_word_s;
            else                  head_d = 12'h000;
         end else if (count_q == CW'(0) && push_s) begin
            head_d = lap_word_s;
         end else begin
            head_d = head_q;
         end
      end
      valid_d = (count_d != CW'(0));
   end

   // Control and tick registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         presc_q    <= '0;
         count_en_q <= 1'b0;
         cnt_clr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         count_en_q <= count_en_d;
         cnt_clr_q  <= cnt_clr_d;
      end
   end

   // FIFO storage, pointers and readout registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAP_DEPTH; i++) mem_q[i] <= 12'h000;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         head_q   <= 12'h000;
         ovf_q    <= 1'b0;
      end else begin
         if (push_s) mem_q[wr_ptr_q] <= lap_word_s;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         head_q   <= head_d;
         ovf_q    <= ovf_d;
      end
   end

   assign count_en            = count_en_q;
   assign cnt_clr             = cnt_clr_q;
   assign status              = state_q;
   assign lap_if.lap_valid    = valid_q;
   assign lap_if.lap_data     = head_q;
   assign lap_if.lap_count    = count_q;
   assign lap_if.lap_overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl: vector table plus hand sequences for
// overflow, tick spacing across a pause and asynchronous reset.
module tb_stopwatch_lap_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start_s, stop_s, reset_s, lap_s;
   logic [5:0] cur_min_s, cur_sec_s;
   logic       count_en_s, cnt_clr_s;
   logic [1:0] status_s;

   int n_chk;
   int n_fail;

   stopwatch_lap_ctrl_if #(.LAP_DEPTH(4)) lif ();

   stopwatch_lap_ctrl #(.TICK_DIV(4), .LAP_DEPTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_s),
      .stop     (stop_s),
      .reset    (reset_s),
      .lap      (lap_s),
      .cur_min  (cur_min_s),
      .cur_sec  (cur_sec_s),
      .count_en (count_en_s),
      .cnt_clr  (cnt_clr_s),
      .status   (status_s),
      .lap_if   (lif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       st, sp, rs, lp, rdy;
      logic [5:0] mn, sc;
      logic [1:0] e_status;
      logic       e_ce, e_clr, e_valid;
      logic [2:0] e_cnt;
      logic [11:0] e_data;
      logic       e_ovf;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic sp, input logic rs, input logic lp,
                        input logic rdy, input logic [5:0] mn, input logic [5:0] sc);
      start_s        = st;
      stop_s         = sp;
      reset_s        = rs;
      lap_s          = lp;
      lif.lap_ready  = rdy;
      cur_min_s      = mn;
      cur_sec_s      = sc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " status"},   32'(status_s),         32'd0);
      chk({tag, " count_en"}, 32'(count_en_s),       32'd0);
      chk({tag, " cnt_clr"},  32'(cnt_clr_s),        32'd0);
      chk({tag, " valid"},    32'(lif.lap_valid),    32'd0);
      chk({tag, " count"},    32'(lif.lap_count),    32'd0);
      chk({tag, " data"},     32'(lif.lap_data),     32'd0);
      chk({tag, " ovf"},      32'(lif.lap_overflow), 32'd0);
   endtask

   initial begin
      logic [11:0] lap_words [6];
      int          pulses [$];
      int          exp_pulse [6];
      int          clr_seen;

      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);

      //          st    sp    rs    lp    rdy   min    sec     status ce    clr   valid cnt   data     ovf
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1,  6'd1,  2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd5,  2'd1, 1'b0, 1'b0, 1'b1, 3'd1, 12'h005, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  2'd1, 1'b0, 1'b0, 1'b1, 3'd1, 12'h005, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  2'd1, 1'b0, 1'b0, 1'b1, 3'd1, 12'h005, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  2'd1, 1'b1, 1'b0, 1'b1, 3'd1, 12'h005, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd2,  6'd59, 2'd1, 1'b0, 1'b0, 1'b1, 3'd2, 12'h005, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  6'd0,  2'd1, 1'b0, 1'b0, 1'b1, 3'd1, 12'h0BB, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  6'd0,  2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  2'd2, 1'b1, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  6'd0,  2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd3,  6'd0,  2'd2, 1'b0, 1'b0, 1'b1, 3'd1, 12'h0C0, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  2'd1, 1'b0, 1'b0, 1'b1, 3'd1, 12'h0C0, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd4,  6'd4,  2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 12'h000, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0};

      #12;
      chk_reset_state("por");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].st, tbl[i].sp, tbl[i].rs, tbl[i].lp, tbl[i].rdy, tbl[i].mn, tbl[i].sc);
         step();
         chk($sformatf("v%0d status", i),   32'(status_s),         32'(tbl[i].e_status));
         chk($sformatf("v%0d count_en", i), 32'(count_en_s),       32'(tbl[i].e_ce));
         chk($sformatf("v%0d cnt_clr", i),  32'(cnt_clr_s),        32'(tbl[i].e_clr));
         chk($sformatf("v%0d valid", i),    32'(lif.lap_valid),    32'(tbl[i].e_valid));
         chk($sformatf("v%0d count", i),    32'(lif.lap_count),    32'(tbl[i].e_cnt));
         chk($sformatf("v%0d data", i),     32'(lif.lap_data),     32'(tbl[i].e_data));
         chk($sformatf("v%0d ovf", i),      32'(lif.lap_overflow), 32'(tbl[i].e_ovf));
      end

      // Overflow on a full FIFO, then lap+pop on full, then continuous drain.
      for (int i = 0; i < 6; i++) lap_words[i] = {6'(i + 1), 6'(10 + i)};
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
      step();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, lap_words[i][11:6], lap_words[i][5:0]);
         step();
         if (i == 3) chk("ovf before full drop", 32'(lif.lap_overflow), 32'd0);
      end
      chk("full count", 32'(lif.lap_count),    32'd4);
      chk("full ovf",   32'(lif.lap_overflow), 32'd1);
      chk("full head",  32'(lif.lap_data),     32'(lap_words[0]));
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, lap_words[5][11:6], lap_words[5][5:0]);
      step();
      chk("lap+pop count", 32'(lif.lap_count),    32'd4);
      chk("lap+pop ovf",   32'(lif.lap_overflow), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain%0d valid", i), 32'(lif.lap_valid), 32'd1);
         chk($sformatf("drain%0d data", i),  32'(lif.lap_data),  32'(lap_words[i + 1 + ((i == 3) ? 1 : 0)]));
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
         step();
      end
      chk("drained valid", 32'(lif.lap_valid), 32'd0);
      chk("drained count", 32'(lif.lap_count), 32'd0);
      chk("ovf sticky",    32'(lif.lap_overflow), 32'd1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
      step();
      chk("clr ovf cleared", 32'(lif.lap_overflow), 32'd0);
      chk("clr pulse",       32'(cnt_clr_s),        32'd1);
      chk("clr status",      32'(status_s),         32'd0);

      // Tick spacing: 20 running, pause of 10 status cycles, 6 running.
      exp_pulse = '{4, 8, 12, 16, 20, 34};
      clr_seen  = 0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
      step();
      chk("tick start status", 32'(status_s), 32'd1);
      for (int k = 1; k <= 37; k++) begin
         drive((k == 31), (k == 21), 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
         step();
         if (count_en_s) pulses.push_back(k);
         if (cnt_clr_s) clr_seen++;
         if (k == 21) chk("tick paused status", 32'(status_s), 32'd2);
         if (k == 30) chk("tick still paused",  32'(status_s), 32'd2);
         if (k == 31) chk("tick resume status", 32'(status_s), 32'd1);
      end
      chk("tick pulse count", 32'(pulses.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < pulses.size()) chk($sformatf("tick pulse%0d cycle", i), 32'(pulses[i]), 32'(exp_pulse[i]));
      end
      chk("tick no cnt_clr", 32'(clr_seen), 32'd0);

      // Asynchronous rst_n mid-run with three laps stored.
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'(i), 6'(i + 20));
         step();
      end
      chk("pre-rst count", 32'(lif.lap_count), 32'd3);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_state("async");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rst low%0d count_en", i), 32'(count_en_s), 32'd0);
         chk($sformatf("rst low%0d cnt_clr", i),  32'(cnt_clr_s),  32'd0);
      end
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
      step();
      chk("post-rst status", 32'(status_s),      32'd0);
      chk("post-rst valid",  32'(lif.lap_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_lap_ctrl.md
# stopwatch_lap_ctrl

Run/pause/clear sequencer and lap-capture unit for the stopwatch seconds/minutes counter chain. Replaces the bare control FSM. It divides the system clock into a one-cycle count-enable tick for the seconds counter and issues a synchronous clear to both counters. It also snapshots the live {minutes, seconds} value into a small lap FIFO, which a display/readout block drains with a valid/ready handshake.

## Interface
- TICK_DIV, 100: clk cycles per count tick; legal range 2..2^16.
- LAP_DEPTH, 4: lap FIFO entries; power of two, 2..16.
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse: run / resume
- stop  input  1  single-cycle pulse: pause
- reset  input  1  single-cycle pulse: clear time, laps, overflow
- lap  input  1  single-cycle pulse: capture current time
- cur_min  input  6  live minutes from minutes counter
- cur_sec  input  6  live seconds from seconds counter
- count_en  output  1  one-cycle tick to seconds counter enable
- cnt_clr  output  1  one-cycle synchronous clear to both counters
- status  output  2  00 IDLE, 01 RUNNING, 10 PAUSED; 11 never driven
- lap_valid  output  1  FIFO non-empty
- lap_ready  input  1  consumer accepts head entry
- lap_data  output  12  head entry {min[5:0], sec[5:0]}
- lap_count  output  $clog2(LAP_DEPTH)+1  current occupancy
- lap_overflow  output  1  sticky: a lap was dropped because the FIFO was full

## Operation
- FSM states IDLE, RUNNING, PAUSED; status is the registered state.
- Command priority within a cycle: reset > stop > start; lap is evaluated independently.
- IDLE: start -> RUNNING. stop ignored.
- RUNNING: stop -> PAUSED. start ignored.
- PAUSED: start -> RUNNING, prescaler resumes from its held value. stop ignored.
- reset in any state:
  - next state IDLE
  - cnt_clr high for exactly 1 cycle
  - prescaler := 0
  - FIFO flushed; lap_count := 0
  - lap_overflow := 0
  - a lap on the same cycle is discarded
- Prescaler counts 0..TICK_DIV-1 only in RUNNING and wraps to 0.
  - count_en is registered; it is high for the cycle after the prescaler reaches TICK_DIV-1.
  - The prescaler holds its value in PAUSED and IDLE.
- Lap capture is active in RUNNING and PAUSED; lap is ignored in IDLE.
  - Push {cur_min, cur_sec} as sampled at that edge. A coincident count_en does not alter the captured value (pre-increment value is stored).
  - If full and no pop this cycle: entry dropped, lap_overflow := 1, held until reset or rst_n.
  - If full with a simultaneous pop: push accepted, no overflow.
- Read handshake:
  - lap_data is valid whenever lap_valid=1 and stays stable until popped.
  - Pop occurs on a cycle with lap_valid & lap_ready.
  - lap_ready with an empty FIFO has no effect.
- lap_count = pushes − pops, saturating at LAP_DEPTH. Pointers wrap modulo LAP_DEPTH.

## Timing
- rst_n low (async):
  - status=00, count_en=0, cnt_clr=0
  - prescaler=0, lap_valid=0, lap_count=0, lap_overflow=0
  - lap_data=0
- Command latency: status changes 1 cycle after the start/stop/reset pulse.
- Tick latency: the first count_en comes TICK_DIV cycles after status becomes 01. Subsequent ticks are every TICK_DIV cycles of RUNNING time, with PAUSED cycles excluded.
- cnt_clr asserts on the cycle status becomes 00 due to reset. count_en is never high in that same cycle.
- Lap push to lap_valid: 1 cycle when the FIFO was empty; no bypass.
- The pop-to-next-head update is registered. The new head is visible the cycle after the pop.
- Throughput: 1 push and 1 pop per cycle sustained.

## Test plan
- rst_n pulse mid-RUNNING with TICK_DIV=4 and 3 laps stored -> all outputs return to reset values immediately. No count_en and no cnt_clr pulse occur while rst_n is low.
- TICK_DIV=4: start, run 20 cycles, stop, wait 10, start, run 6 -> exactly 6 count_en pulses at 4-cycle spacing. The pause shifts the next pulse by exactly 10 cycles. status sequence is 00→01→10→01.
- cur_min=2, cur_sec=59 with lap and count_en in the same cycle -> the stored entry is 12'h0BB, i.e. {2,59}.
- LAP_DEPTH=4, lap_ready=0, 5 laps -> lap_count=4, lap_overflow=1, first 4 entries retained in order. Then a simultaneous lap+pop on a full FIFO -> lap_count stays 4 and the new entry is at the tail.
- Drain with lap_ready=1 continuously -> one entry per cycle, in FIFO order. lap_valid drops the cycle after the last pop.
- reset together with stop and lap while RUNNING -> status=00, one cnt_clr cycle, FIFO empty, lap_overflow=0. The lap is not stored.
